// File: rtl/kbd_char_fifo.sv
// kbd_char_fifo: PS/2 set-2 keyboard front end for the CPU character I/O path.
//
// A registered decode stage takes scan bytes, a small FSM drops break (F0 xx) and
// extended (E0 xx / E0 F0 xx) sequences, make codes are translated to ASCII and
// pushed into a DEPTH-entry FIFO. The FIFO head is presented registered on ASCII
// and fifo_ready; every successful pop moves the VGA text cursor char_cnt.
//
// Optional build macro: KBD_SHIFT_EN adds a shift-held flag (0x12 / 0x59) that
// selects uppercase letters and US shifted digit symbols.
//
// Ports:
//   clk         in   system clock
//   rst_out     in   synchronous active-high reset
//   scan_code   in   PS/2 byte from the receiver
//   scan_valid  in   one-cycle strobe qualifying scan_code
//   pop         in   one-cycle consume request from the I/O bus
//   ASCII       out  FIFO head character, 0x00 when empty
//   fifo_ready  out  FIFO non-empty
//   char_cnt    out  cursor position, 0 .. COLS*ROWS-1
//   overflow    out  sticky: a character was dropped on a full FIFO

module kbd_char_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 60
) (
  input  logic        clk,
  input  logic        rst_out,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  input  logic        pop,
  output logic [7:0]  ASCII,
  output logic        fifo_ready,
  output logic [12:0] char_cnt,
  output logic        overflow
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam int unsigned     CurMax  = COLS * ROWS;
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StBreak, StExt} state_e;

  // Set-2 make code to ASCII; bit 8 flags a hit.
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = shift ? ")" : "0";
      8'h16: ch = shift ? "!" : "1";
      8'h1E: ch = shift ? "@" : "2";
      8'h26: ch = shift ? "#" : "3";
      8'h25: ch = shift ? "$" : "4";
      8'h2E: ch = shift ? "%" : "5";
      8'h36: ch = shift ? "^" : "6";
      8'h3D: ch = shift ? "&" : "7";
      8'h3E: ch = shift ? "*" : "8";
      8'h46: ch = shift ? "(" : "9";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    if (shift && ch >= "a" && ch <= "z") ch = ch - 8'h20;
    return {(ch != 8'h00), ch};
  endfunction

  // Decode stage register
  logic [7:0] code_q;
  logic       code_vld_q;

  always_ff @(posedge clk) begin
    if (rst_out) begin
      code_q     <= 8'h00;
      code_vld_q <= 1'b0;
    end else begin
      code_q     <= scan_code;
      code_vld_q <= scan_valid;
    end
  end

  // Decoder FSM
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst_out) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (code_vld_q) begin
      unique case (state_q)
        StIdle: begin
          if (code_q == 8'hF0)      state_d = StBreak;
          else if (code_q == 8'hE0) state_d = StExt;
        end
        StBreak: state_d = StIdle;
        StExt:   state_d = (code_q == 8'hF0) ? StBreak : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  logic shift_held;

`ifdef KBD_SHIFT_EN
  logic shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (code_vld_q && (code_q == 8'h12 || code_q == 8'h59)) begin
      if (state_q == StIdle)       shift_d = 1'b1;
      else if (state_q == StBreak) shift_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_out) shift_q <= 1'b0;
    else         shift_q <= shift_d;
  end

  assign shift_held = shift_q;
`else
  assign shift_held = 1'b0;
`endif

  // FSM outputs: a translated character only for plain make codes in IDLE
  logic       push_vld;
  logic [7:0] push_char;

  always_comb begin
    push_vld  = 1'b0;
    push_char = 8'h00;
    if (code_vld_q && state_q == StIdle && code_q != 8'hF0 && code_q != 8'hE0) begin
      {push_vld, push_char} = xlate(code_q, shift_held);
    end
  end

  // FIFO
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PtrW:0]   cnt_q, cnt_d, cnt_rem;
  logic            do_pop, do_push, drop;
  logic [7:0]      ascii_q, ascii_d;
  logic            ready_q, overflow_q;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // A pop frees the slot first, so a full FIFO still accepts the push.
    do_push = push_vld && ((cnt_q != CntFull) || do_pop);
    drop    = push_vld && !do_push;
    rd_d    = do_pop  ? rd_q + PtrOne : rd_q;
    wr_d    = do_push ? wr_q + PtrOne : wr_q;
    cnt_rem = do_pop  ? cnt_q - CntOne : cnt_q;
    cnt_d   = do_push ? cnt_rem + CntOne : cnt_rem;
    // Next head: bypass the incoming character when nothing older remains.
    if (cnt_d == '0)        ascii_d = 8'h00;
    else if (cnt_rem == '0) ascii_d = push_char;
    else                    ascii_d = mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (rst_out) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      ascii_q    <= 8'h00;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      ascii_q    <= ascii_d;
      ready_q    <= (cnt_d != '0);
      overflow_q <= overflow_q | drop;
    end
  end

  // Cursor: the popped character is the registered head
  logic [12:0] cur_q, cur_d;
  int unsigned row_end;

  always_comb begin
    cur_d   = cur_q;
    row_end = (32'(cur_q) / COLS + 1) * COLS;
    if (do_pop) begin
      if (ascii_q == 8'h0D)      cur_d = (row_end >= CurMax) ? 13'd0 : 13'(row_end);
      else if (ascii_q == 8'h08) cur_d = (cur_q == 13'd0) ? 13'd0 : cur_q - 13'd1;
      else                       cur_d = (cur_q == 13'(CurMax - 1)) ? 13'd0 : cur_q + 13'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_out) cur_q <= 13'd0;
    else         cur_q <= cur_d;
  end

  assign ASCII      = ascii_q;
  assign fifo_ready = ready_q;
  assign char_cnt   = cur_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Directed self-checking bench for kbd_char_fifo.

module tb_kbd_char_fifo;

  logic        clk = 1'b0;
  logic        rst_out;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        pop;
  logic [7:0]  ASCII;
  logic        fifo_ready;
  logic [12:0] char_cnt;
  logic        overflow;

  int unsigned chk_cnt = 0;
  int unsigned err_cnt = 0;

`ifdef KBD_SHIFT_EN
  localparam logic [7:0] ExpShiftA = 8'h41;
`else
  localparam logic [7:0] ExpShiftA = 8'h61;
`endif

  kbd_char_fifo #(
    .DEPTH(16),
    .COLS (80),
    .ROWS (60)
  ) u_dut (
    .clk       (clk),
    .rst_out   (rst_out),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .pop       (pop),
    .ASCII     (ASCII),
    .fifo_ready(fifo_ready),
    .char_cnt  (char_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    scan_code  = c;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst_out = 1'b1;
    tick();
    rst_out = 1'b0;
  endtask

  // Queue one character and consume it, n times.
  task automatic type_chars(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      send(c);
      tick();
      do_pop();
    end
  endtask

  initial begin
    rst_out    = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    pop        = 1'b0;
    tick();
    tick();
    rst_out = 1'b0;

    check_eq("rst_ascii", ASCII, 8'h00);
    check_eq("rst_ready", fifo_ready, 0);
    check_eq("rst_cnt", char_cnt, 0);
    check_eq("rst_ovf", overflow, 0);

    // Make then break of 'a': one entry, visible two cycles after strobe
    send(8'h1C);
    send(8'hF0);
    check_eq("lat_ascii", ASCII, 8'h61);
    check_eq("lat_ready", fifo_ready, 1);
    send(8'h1C);
    tick();
    tick();
    check_eq("brk_ascii", ASCII, 8'h61);
    do_pop();
    check_eq("one_ready", fifo_ready, 0);
    check_eq("one_ascii", ASCII, 8'h00);
    check_eq("one_cnt", char_cnt, 1);

    // Overflow: 17 pushes into 16 entries
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h16);
    tick();
    check_eq("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check_eq("ovf_head", ASCII, 8'h31);
      do_pop();
    end
    check_eq("ovf_empty", fifo_ready, 0);
    check_eq("ovf_cnt", char_cnt, 16);
    check_eq("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) send(8'h16);
    tick();
    check_eq("full_ovf0", overflow, 0);
    send(8'h32);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check_eq("full_ovf1", overflow, 0);
    for (int i = 0; i < 15; i++) begin
      check_eq("full_head", ASCII, 8'h31);
      do_pop();
    end
    check_eq("full_tail", ASCII, 8'h62);
    do_pop();
    check_eq("full_empty", fifo_ready, 0);
    check_eq("full_cnt", char_cnt, 17);

    // Cursor movement
    do_reset();
    type_chars(8'h5A, 1);
    type_chars(8'h16, 5);
    check_eq("cur_85", char_cnt, 85);
    type_chars(8'h5A, 1);
    check_eq("cur_enter", char_cnt, 160);
    type_chars(8'h66, 1);
    check_eq("cur_bs", char_cnt, 159);
    type_chars(8'h16, 1);
    type_chars(8'h5A, 57);
    check_eq("cur_4720", char_cnt, 4720);
    type_chars(8'h16, 79);
    check_eq("cur_4799", char_cnt, 4799);
    type_chars(8'h1C, 1);
    check_eq("cur_wrap", char_cnt, 0);
    type_chars(8'h66, 1);
    check_eq("cur_bs_sat", char_cnt, 0);
    type_chars(8'h5A, 59);
    check_eq("cur_row59", char_cnt, 4720);
    type_chars(8'h5A, 1);
    check_eq("cur_enter_wrap", char_cnt, 0);

    // Extended make and break are discarded
    do_reset();
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    tick();
    check_eq("ext_empty", fifo_ready, 0);
    send(8'h29);
    tick();
    check_eq("ext_space", ASCII, 8'h20);

    // Shift handling (lowercase only when the shift feature is absent)
    do_reset();
    send(8'h12);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    send(8'h1C);
    tick();
    check_eq("shift_first", ASCII, ExpShiftA);
    do_pop();
    check_eq("shift_second", ASCII, 8'h61);
    do_pop();
    check_eq("shift_empty", fifo_ready, 0);

    // Reset while in BREAK returns to IDLE
    do_reset();
    send(8'hF0);
    do_reset();
    check_eq("rbrk_empty", fifo_ready, 0);
    send(8'h1C);
    tick();
    check_eq("rbrk_ascii", ASCII, 8'h61);

    // Byte strobed during reset is discarded
    rst_out    = 1'b1;
    scan_code  = 8'h1C;
    scan_valid = 1'b1;
    tick();
    rst_out    = 1'b0;
    scan_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_strobe", fifo_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
